// File: rtl/mcb_port_model.sv
// Behavioural model of a single MCB user port: a 4-deep command FIFO,
// write/read data FIFOs, a word-addressed backing memory, and a small
// dispatcher FSM that executes write/read bursts strictly in command order.
module mcb_port_model #(
    parameter int MEM_AW       = 10,
    parameter int FIFO_AW      = 6,
    parameter int CALIB_CYCLES = 64
) (
    input  logic               clk_100mhz,
    input  logic               sys_rst_n,
    output logic               calib_done,
    input  logic               cmd_en,
    input  logic [2:0]         cmd_instr,
    input  logic [5:0]         cmd_bl,
    input  logic [29:0]        cmd_byte_addr,
    output logic               cmd_empty,
    output logic               cmd_full,
    input  logic               wr_en,
    input  logic [3:0]         wr_mask,
    input  logic [31:0]        wr_data,
    output logic               wr_empty,
    output logic               wr_full,
    output logic [FIFO_AW:0]   wr_count,
    input  logic               rd_en,
    output logic [31:0]        rd_data,
    output logic               rd_empty,
    output logic               rd_full,
    output logic [FIFO_AW:0]   rd_count,
    output logic [3:0]         err_flags
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CCW   = $clog2(CALIB_CYCLES + 1) + 1;
    // Common width for comparing FIFO occupancy against burst length + 1.
    localparam int CW    = FIFO_AW + 8;

    typedef enum logic [1:0] {IDLE = 2'd0, WR_BURST = 2'd1, RD_BURST = 2'd2} state_t;

    // ---------------- calibration ----------------
    logic [CCW-1:0] r_calib_cnt;

    // Count clocks after reset release, saturating at CALIB_CYCLES.
    always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
        if (!sys_rst_n)                            r_calib_cnt <= '0;
        else if (r_calib_cnt != CCW'(CALIB_CYCLES)) r_calib_cnt <= r_calib_cnt + 1'b1;
    end

    assign calib_done = (r_calib_cnt == CCW'(CALIB_CYCLES));

    // ---------------- command FIFO (depth 4) ----------------
    logic [2:0]        r_cq_instr [4];
    logic [5:0]        r_cq_bl    [4];
    logic [MEM_AW-1:0] r_cq_addr  [4];
    logic [1:0]        r_cq_wp, r_cq_rp;
    logic [2:0]        r_cq_cnt;
    logic              w_cmd_push, w_cmd_pop;
    logic [2:0]        w_hd_instr;
    logic [5:0]        w_hd_bl;
    logic [MEM_AW-1:0] w_hd_addr;
    logic              w_unused_addr;

    assign w_cmd_push    = cmd_en && calib_done && !cmd_full;
    assign cmd_empty     = (r_cq_cnt == 3'd0);
    assign cmd_full      = (r_cq_cnt == 3'd4);
    assign w_hd_instr    = r_cq_instr[r_cq_rp];
    assign w_hd_bl       = r_cq_bl[r_cq_rp];
    assign w_hd_addr     = r_cq_addr[r_cq_rp];
    // Byte-lane bits and address bits above the memory are ignored.
    assign w_unused_addr = ^{cmd_byte_addr[29:MEM_AW+2], cmd_byte_addr[1:0]};

    // Command storage; only the word address is kept.
    always_ff @(posedge clk_100mhz) begin
        if (w_cmd_push) begin
            r_cq_instr[r_cq_wp] <= cmd_instr;
            r_cq_bl[r_cq_wp]    <= cmd_bl;
            r_cq_addr[r_cq_wp]  <= cmd_byte_addr[MEM_AW+1:2];
        end
    end

    // Command FIFO pointers and occupancy.
    always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cq_wp  <= '0;
            r_cq_rp  <= '0;
            r_cq_cnt <= '0;
        end else begin
            if (w_cmd_push) r_cq_wp <= r_cq_wp + 1'b1;
            if (w_cmd_pop)  r_cq_rp <= r_cq_rp + 1'b1;
            case ({w_cmd_push, w_cmd_pop})
                2'b10:   r_cq_cnt <= r_cq_cnt + 1'b1;
                2'b01:   r_cq_cnt <= r_cq_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    // ---------------- write data FIFO ----------------
    // Entry layout: {mask[3:0], data[31:0]}.
    logic [35:0]        r_wq [DEPTH];
    logic [FIFO_AW-1:0] r_wq_wp, r_wq_rp;
    logic [FIFO_AW:0]   r_wq_cnt;
    logic               w_wr_push, w_wr_pop;
    logic [35:0]        w_wq_head;

    assign w_wr_push = wr_en && !wr_full;
    assign wr_empty  = (r_wq_cnt == '0);
    assign wr_full   = (r_wq_cnt == (FIFO_AW+1)'(DEPTH));
    assign wr_count  = r_wq_cnt;
    assign w_wq_head = r_wq[r_wq_rp];

    // Write FIFO storage (accepted even before calibration completes).
    always_ff @(posedge clk_100mhz) begin
        if (w_wr_push) r_wq[r_wq_wp] <= {wr_mask, wr_data};
    end

    // Write FIFO pointers and occupancy.
    always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_wq_wp  <= '0;
            r_wq_rp  <= '0;
            r_wq_cnt <= '0;
        end else begin
            if (w_wr_push) r_wq_wp <= r_wq_wp + 1'b1;
            if (w_wr_pop)  r_wq_rp <= r_wq_rp + 1'b1;
            case ({w_wr_push, w_wr_pop})
                2'b10:   r_wq_cnt <= r_wq_cnt + 1'b1;
                2'b01:   r_wq_cnt <= r_wq_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    // ---------------- read data FIFO ----------------
    logic [31:0]        r_rq [DEPTH];
    logic [FIFO_AW-1:0] r_rq_wp, r_rq_rp;
    logic [FIFO_AW:0]   r_rq_cnt;
    logic [31:0]        r_rd_last;
    logic [31:0]        r_mem_rdata;
    logic               r_rd_vld;
    logic               w_rd_pop;

    assign w_rd_pop = rd_en && !rd_empty;
    assign rd_empty = (r_rq_cnt == '0);
    assign rd_full  = (r_rq_cnt == (FIFO_AW+1)'(DEPTH));
    assign rd_count = r_rq_cnt;
    // When empty, rd_data keeps showing the last word popped (0 after reset).
    assign rd_data  = rd_empty ? r_rd_last : r_rq[r_rq_rp];

    // Read FIFO storage, fed by the memory read pipeline.
    always_ff @(posedge clk_100mhz) begin
        if (r_rd_vld) r_rq[r_rq_wp] <= r_mem_rdata;
    end

    // Read FIFO pointers, occupancy and held output word.
    always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_rq_wp   <= '0;
            r_rq_rp   <= '0;
            r_rq_cnt  <= '0;
            r_rd_last <= '0;
        end else begin
            if (r_rd_vld) r_rq_wp <= r_rq_wp + 1'b1;
            if (w_rd_pop) begin
                r_rq_rp   <= r_rq_rp + 1'b1;
                r_rd_last <= r_rq[r_rq_rp];
            end
            case ({r_rd_vld, w_rd_pop})
                2'b10:   r_rq_cnt <= r_rq_cnt + 1'b1;
                2'b01:   r_rq_cnt <= r_rq_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    // ---------------- dispatcher FSM ----------------
    state_t            r_state, w_state_nxt;
    logic [5:0]        r_left;
    logic [MEM_AW-1:0] r_addr;
    logic              w_illegal;
    logic [CW-1:0]     w_need, w_rd_free;

    assign w_need    = CW'(w_hd_bl) + CW'(1);
    // Free read slots minus the word still in the memory read pipeline.
    assign w_rd_free = CW'(DEPTH) - CW'(r_rq_cnt) - CW'(r_rd_vld);
    assign w_wr_pop  = (r_state == WR_BURST);

    // State register.
    always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
        if (!sys_rst_n) r_state <= IDLE;
        else            r_state <= w_state_nxt;
    end

    // Next state and head-of-queue pop decision.
    always_comb begin
        w_state_nxt = r_state;
        w_cmd_pop   = 1'b0;
        w_illegal   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!cmd_empty) begin
                    casez (w_hd_instr)
                        3'b0?0: if (CW'(r_wq_cnt) >= w_need) begin
                                    w_cmd_pop   = 1'b1;
                                    w_state_nxt = WR_BURST;
                                end
                        3'b0?1: if (w_rd_free >= w_need) begin
                                    w_cmd_pop   = 1'b1;
                                    w_state_nxt = RD_BURST;
                                end
                        3'b10?: w_cmd_pop = 1'b1;
                        default: begin
                            w_cmd_pop = 1'b1;
                            w_illegal = 1'b1;
                        end
                    endcase
                end
            end
            WR_BURST, RD_BURST: if (r_left == 6'd0) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Burst address / remaining-beat tracking.
    always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_addr <= '0;
            r_left <= '0;
        end else if (w_cmd_pop) begin
            r_addr <= w_hd_addr;
            r_left <= w_hd_bl;
        end else if (r_state != IDLE) begin
            r_addr <= r_addr + 1'b1;
            r_left <= r_left - 1'b1;
        end
    end

    // ---------------- backing memory (never reset) ----------------
    logic [31:0] r_mem [1 << MEM_AW];

    // Masked write per WR_BURST beat; registered read per RD_BURST beat.
    // wr_mask is ordered MSB-byte first: wr_mask[3-b] suppresses byte b.
    always_ff @(posedge clk_100mhz) begin
        if (r_state == WR_BURST) begin
            for (int b = 0; b < 4; b++) begin
                if (!w_wq_head[35-b]) r_mem[r_addr][8*b +: 8] <= w_wq_head[8*b +: 8];
            end
        end
        if (r_state == RD_BURST) r_mem_rdata <= r_mem[r_addr];
    end

    // Read pipeline valid; cleared by reset so an aborted burst pushes nothing.
    always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
        if (!sys_rst_n) r_rd_vld <= 1'b0;
        else            r_rd_vld <= (r_state == RD_BURST);
    end

    // ---------------- sticky error flags ----------------
    logic [3:0] r_err;

    // Accumulate overflow/underflow/illegal events until reset.
    always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
        if (!sys_rst_n) r_err <= '0;
        else            r_err <= r_err | {w_illegal, rd_en && rd_empty,
                                          wr_en && wr_full, cmd_en && cmd_full};
    end

    assign err_flags = r_err;

endmodule

// File: tb/tb_mcb_port_model.sv
// Randomized scoreboard bench for mcb_port_model with a command-level memory model.
module tb_mcb_port_model;
    localparam int MEM_AW  = 10;
    localparam int FIFO_AW = 6;
    localparam int CALIB   = 16;
    localparam int MEMW    = 1 << MEM_AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic               calib_done, cmd_en, cmd_empty, cmd_full;
    logic [2:0]         cmd_instr;
    logic [5:0]         cmd_bl;
    logic [29:0]        cmd_byte_addr;
    logic               wr_en, wr_empty, wr_full;
    logic [3:0]         wr_mask;
    logic [31:0]        wr_data;
    logic [FIFO_AW:0]   wr_count, rd_count;
    logic               rd_en, rd_empty, rd_full;
    logic [31:0]        rd_data;
    logic [3:0]         err_flags;

    mcb_port_model #(.MEM_AW(MEM_AW), .FIFO_AW(FIFO_AW), .CALIB_CYCLES(CALIB)) dut (
        .clk_100mhz(clk), .sys_rst_n(rst_n), .calib_done(calib_done),
        .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl), .cmd_byte_addr(cmd_byte_addr),
        .cmd_empty(cmd_empty), .cmd_full(cmd_full),
        .wr_en(wr_en), .wr_mask(wr_mask), .wr_data(wr_data),
        .wr_empty(wr_empty), .wr_full(wr_full), .wr_count(wr_count),
        .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty), .rd_full(rd_full),
        .rd_count(rd_count), .err_flags(err_flags));

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out", name);
    endtask

    // ---------------- reference model (command level) ----------------
    typedef struct {logic [2:0] instr; int bl; int wa;} mcmd_t;
    typedef struct {logic [31:0] d; logic [3:0] m;} wword_t;

    mcmd_t       pend_q[$];
    wword_t      wq[$];
    logic [31:0] exp_q[$];
    logic [31:0] ref_mem [MEMW];

    // Execute queued commands in order until a write lacks its data words.
    function automatic void model_run();
        while (pend_q.size() > 0) begin
            mcmd_t c;
            c = pend_q[0];
            if (c.instr == 3'b000 || c.instr == 3'b010) begin
                if (wq.size() < c.bl + 1) break;
                for (int i = 0; i <= c.bl; i++) begin
                    wword_t w;
                    int a;
                    w = wq.pop_front();
                    a = (c.wa + i) % MEMW;
                    // mask bit (3-b) = 1 leaves byte b untouched
                    for (int b = 0; b < 4; b++)
                        if (!w.m[3-b]) ref_mem[a][8*b +: 8] = w.d[8*b +: 8];
                end
            end else if (c.instr == 3'b001 || c.instr == 3'b011) begin
                for (int i = 0; i <= c.bl; i++) exp_q.push_back(ref_mem[(c.wa + i) % MEMW]);
            end
            void'(pend_q.pop_front());
        end
    endfunction

    // ---------------- monitor: pop and compare read data ----------------
    logic        rd_take = 1'b0;
    logic        rd_force = 1'b0;
    logic        rd_auto = 1'b0;
    logic [31:0] last_rd = '0;
    assign rd_en = rd_take | rd_force;

    always @(negedge clk) begin
        if (rd_auto && !rd_empty && ($urandom_range(3) != 0)) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rd_unexpected: got 0x%08h, expected no data", rd_data);
            end else begin
                last_rd = exp_q.pop_front();
                check("rd_data", rd_data, last_rd);
            end
            rd_take = 1'b1;
        end else begin
            rd_take = 1'b0;
        end
    end

    // ---------------- stimulus helpers (called at negedge) ----------------
    task automatic push_word(input logic [31:0] d, input logic [3:0] m);
        int n = 0;
        wword_t w;
        while (wr_full && n < 500) begin @(negedge clk); n++; end
        if (wr_full) timeout("push_word");
        else begin
            wr_en = 1'b1; wr_data = d; wr_mask = m;
            w.d = d; w.m = m;
            wq.push_back(w);
            @(negedge clk);
            wr_en = 1'b0;
            model_run();
        end
    endtask

    task automatic issue_cmd(input logic [2:0] ins, input int bl, input logic [29:0] ba);
        int n = 0;
        mcmd_t c;
        while (cmd_full && n < 500) begin @(negedge clk); n++; end
        if (cmd_full) timeout("issue_cmd");
        else begin
            cmd_en = 1'b1; cmd_instr = ins; cmd_bl = 6'(bl); cmd_byte_addr = ba;
            c.instr = ins; c.bl = bl; c.wa = (int'(ba) >> 2) % MEMW;
            pend_q.push_back(c);
            @(negedge clk);
            cmd_en = 1'b0;
            model_run();
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(cmd_empty && wr_empty && rd_empty && exp_q.size() == 0 && pend_q.size() == 0)
               && n < 3000) begin
            @(negedge clk); n++;
        end
        if (n >= 3000) timeout("wait_idle");
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_rd(input string name);
        int n = 0;
        while (rd_empty && n < 100) begin @(negedge clk); n++; end
        if (rd_empty) timeout(name);
    endtask

    task automatic wait_calib();
        int n = 0;
        do begin
            @(negedge clk); n++;
            cmd_en = 1'b0; wr_en = 1'b0;
        end while (!calib_done && n < 1000);
        check("calib_latency", 32'(n), 32'(CALIB));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_calib"},     32'(calib_done), 32'd0);
        check({tag, "_cmd_empty"}, 32'(cmd_empty),  32'd1);
        check({tag, "_cmd_full"},  32'(cmd_full),   32'd0);
        check({tag, "_wr_empty"},  32'(wr_empty),   32'd1);
        check({tag, "_wr_full"},   32'(wr_full),    32'd0);
        check({tag, "_wr_count"},  32'(wr_count),   32'd0);
        check({tag, "_rd_empty"},  32'(rd_empty),   32'd1);
        check({tag, "_rd_full"},   32'(rd_full),    32'd0);
        check({tag, "_rd_count"},  32'(rd_count),   32'd0);
        check({tag, "_rd_data"},   rd_data,         32'd0);
        check({tag, "_err"},       32'(err_flags),  32'd0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        wword_t w0;
        cmd_en = 1'b0; cmd_instr = '0; cmd_bl = '0; cmd_byte_addr = '0;
        wr_en = 1'b0; wr_mask = '0; wr_data = '0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");

        // Release reset; a command before calibration is dropped, a data word is kept.
        rst_n = 1'b1;
        cmd_en = 1'b1; cmd_instr = 3'b001; cmd_bl = 6'd0; cmd_byte_addr = '0;
        wr_en = 1'b1; wr_data = $urandom; wr_mask = 4'b0000;
        w0.d = wr_data; w0.m = wr_mask;
        wq.push_back(w0);
        wait_calib();
        check("precal_cmd_dropped", 32'(cmd_empty), 32'd1);
        check("precal_wr_kept", 32'(wr_count), 32'd1);
        rd_auto = 1'b1;

        // Fill whole memory so every later read has a defined model value.
        for (int k = 0; k < MEMW / 64; k++) begin
            for (int i = 0; i < ((k == 0) ? 63 : 64); i++) push_word($urandom, 4'b0000);
            issue_cmd(3'b000, 63, 30'(k * 256));
        end
        wait_idle();

        // Sequential pattern write then readback.
        for (int i = 0; i < 32; i++) push_word(32'(i), 4'b0000);
        issue_cmd(3'b000, 31, 30'h20);
        issue_cmd(3'b001, 31, 30'h20);
        wait_idle();
        check("seq_err", 32'(err_flags), 32'd0);

        // Single-word latency from an idle port.
        rd_auto = 1'b0;
        push_word(32'hDEADBEEF, 4'b0000);
        issue_cmd(3'b000, 0, 30'h10);
        wait_idle();
        issue_cmd(3'b001, 0, 30'h10);
        @(negedge clk);
        @(negedge clk);
        check("lat_empty_E2", 32'(rd_empty), 32'd1);
        @(negedge clk);
        check("lat_ready_E3", 32'(rd_empty), 32'd0);
        check("lat_data", rd_data, 32'hDEADBEEF);
        rd_auto = 1'b1;
        wait_idle();

        // Byte-masked overwrite.
        rd_auto = 1'b0;
        push_word(32'hFFFFFFFF, 4'b0000);
        issue_cmd(3'b010, 0, 30'h40);
        push_word(32'h12345678, 4'b0101);
        issue_cmd(3'b000, 0, 30'h40);
        issue_cmd(3'b011, 0, 30'h40);
        wait_rd("mask_wait");
        check("mask_data", rd_data, 32'hFF34FF78);
        rd_auto = 1'b1;
        wait_idle();

        // Address wrap at top of memory; upper and byte-lane address bits ignored.
        for (int i = 0; i < 4; i++) push_word($urandom, 4'b0000);
        issue_cmd(3'b000, 3, 30'h0200_0000 | 30'((MEMW - 2) * 4) | 30'h3);
        issue_cmd(3'b001, 3, 30'((MEMW - 2) * 4));
        issue_cmd(3'b001, 1, 30'h0);
        wait_idle();
        check("wrap_err", 32'(err_flags), 32'd0);

        // Command FIFO overflow while the head write waits for data.
        for (int k = 0; k < 5; k++) begin
            mcmd_t c;
            cmd_en = 1'b1; cmd_instr = 3'b000; cmd_bl = 6'd0;
            cmd_byte_addr = 30'(32'h300 + k * 4);
            if (k < 4) begin
                c.instr = 3'b000; c.bl = 0; c.wa = (32'h300 + k * 4) >> 2;
                pend_q.push_back(c);
            end
            @(negedge clk);
            if (k == 3) check("cmd_full_after4", 32'(cmd_full), 32'd1);
        end
        cmd_en = 1'b0;
        check("cmd_overflow_err", 32'(err_flags), 32'b0001);

        // Read underflow: no pop, output holds the last word.
        rd_force = 1'b1;
        @(negedge clk);
        rd_force = 1'b0;
        check("rd_underflow_err", 32'(err_flags), 32'b0101);
        check("rd_hold", rd_data, last_rd);
        for (int i = 0; i < 4; i++) push_word($urandom, 4'($urandom));
        wait_idle();

        // Illegal and refresh commands are consumed.
        issue_cmd(3'b110, 5, 30'h0);
        issue_cmd(3'b100, 0, 30'h0);
        issue_cmd(3'b111, 0, 30'h0);
        issue_cmd(3'b101, 0, 30'h0);
        repeat (4) @(negedge clk);
        check("illegal_err", 32'(err_flags), 32'b1101);
        check("illegal_popped", 32'(cmd_empty), 32'd1);

        // Write FIFO overflow.
        for (int i = 0; i < 64; i++) push_word($urandom, 4'b0000);
        check("wr_full", 32'(wr_full), 32'd1);
        check("wr_count_full", 32'(wr_count), 32'd64);
        wr_en = 1'b1; wr_data = 32'hBAD0BAD0;
        @(negedge clk);
        wr_en = 1'b0;
        check("wr_overflow_err", 32'(err_flags), 32'b1111);
        issue_cmd(3'b000, 63, 30'h800);
        issue_cmd(3'b001, 63, 30'h800);
        wait_idle();

        // Randomized mix of bursts.
        for (int t = 0; t < 40; t++) begin
            int r, bl;
            r  = $urandom_range(9);
            bl = $urandom_range(15);
            if (r < 4) begin
                for (int i = 0; i <= bl; i++) push_word($urandom, 4'($urandom));
                issue_cmd($urandom_range(1) ? 3'b010 : 3'b000, bl, 30'($urandom));
            end else if (r < 8) begin
                issue_cmd($urandom_range(1) ? 3'b011 : 3'b001, bl, 30'($urandom));
            end else begin
                issue_cmd(3'b100, 0, 30'($urandom));
            end
        end
        wait_idle();

        // Reset in the middle of a long read burst.
        rd_auto = 1'b0;
        issue_cmd(3'b001, 31, 30'h20);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_state("midburst_reset");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        wait_calib();
        rd_auto = 1'b1;
        issue_cmd(3'b001, 31, 30'h20);
        wait_idle();
        check("final_err", 32'(err_flags), 32'd0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mcb_port_model.md
MCB_PORT_MODEL -- requirements
Module: mcb_port_model

Interface
REQ-001 Parameter MEM_AW, default 10, backing-memory word-address width (2^MEM_AW 32-bit words).
REQ-002 Parameter FIFO_AW, default 6, write/read data FIFO depth 2^FIFO_AW words.
REQ-003 Parameter CALIB_CYCLES, default 64, clocks from reset release to calib_done.
REQ-004 Single clock; reset asynchronous, active-low.
REQ-005 clk_100mhz  in  1  sole clock; all ports synchronous to rising edge.
REQ-006 sys_rst_n  in  1  asynchronous active-low reset.
REQ-007 calib_done  out  1  high when commands are accepted.
REQ-008 cmd_en  in  1  push command; cmd_instr  in  3  instruction; cmd_bl  in  6  burst length minus 1; cmd_byte_addr  in  30  byte address.
REQ-009 cmd_empty  out  1  / cmd_full  out  1  command FIFO flags (depth 4).
REQ-010 wr_en  in  1  push; wr_mask  in  4  byte mask (1 = byte not written); wr_data  in  32.
REQ-011 wr_empty, wr_full  out  1 each; wr_count  out  FIFO_AW+1  words held.
REQ-012 rd_en  in  1  pop; rd_data  out  32  first-word-fall-through head; rd_empty, rd_full  out  1 each; rd_count  out  FIFO_AW+1.
REQ-013 err_flags  out  4  sticky: [0] cmd overflow, [1] wr overflow, [2] rd underflow, [3] illegal instr.

Function
REQ-014 Word address = cmd_byte_addr[MEM_AW+1:2]; bits [1:0] and upper bits ignored; increments by 1 per word, wraps modulo 2^MEM_AW.
REQ-015 cmd_instr decode: 000/010 write, 001/011 read, 100/101 refresh (no-op), 11x illegal (popped, discarded, err_flags[3] set).
REQ-016 cmd_en with cmd_full high, or calib_done low: command dropped; err_flags[0] set only in full case.
REQ-017 wr_en with wr_full high: word dropped, err_flags[1] set; rd_en with rd_empty high: no pop, rd_data holds, err_flags[2] set.
REQ-018 Simultaneous push and pop on any FIFO: count unchanged, both occur; wr_en allowed while calib_done low.
REQ-019 FSM states IDLE, WR_BURST, RD_BURST; commands execute strictly in order.
REQ-020 IDLE -> WR_BURST: head is write and wr_count >= cmd_bl+1; head popped on that edge.
REQ-021 IDLE -> RD_BURST: head is read and free read-FIFO slots minus in-flight words >= cmd_bl+1; head popped.
REQ-022 IDLE with refresh/illegal head: pop, remain IDLE (1 cycle consumed); otherwise unqualified head waits, not popped.
REQ-023 WR_BURST: one wr-FIFO word popped and written to memory per clock with mask applied, cmd_bl+1 words, then IDLE.
REQ-024 RD_BURST: one memory read per clock, cmd_bl+1 words; memory has 1-cycle read latency; data pushed to read FIFO next edge; then IDLE.
REQ-025 Latency, all FIFOs empty: cmd accepted at edge E0; dispatch at E1; write word0 in memory at E2; read word0 visible (rd_empty low) after E3, subsequent words one per clock.
REQ-026 Read following write to same address in command order returns written data (no hazard).
REQ-027 Read FIFO never overflows by construction (REQ-021 reservation).

Reset
REQ-028 Reset asserted: state IDLE, all FIFOs flushed, cmd_empty/wr_empty/rd_empty 1, full flags 0, counts 0, rd_data 0, err_flags 0, calib_done 0, calib counter 0.
REQ-029 Reset mid-burst aborts burst immediately; memory contents are not reset and retain already-written words.
REQ-030 calib_done rises exactly CALIB_CYCLES clocks after reset release, stays high until next reset.

Verification
REQ-031 Write 32 words 0x0000_0000..0x0000_001F, write cmd bl=31 addr 0x20, read cmd bl=31 addr 0x20 -> 32 reads return same sequence; err_flags 0.
REQ-032 Read cmd bl=0 addr 0x10 after write word 0xDEADBEEF mask 4'b0000 -> rd_empty low after E3, rd_data 0xDEADBEEF.
REQ-033 Write 0xFFFFFFFF, then 0x12345678 mask 4'b0101 same addr, read -> 0xFF34FF78.
REQ-034 Write bl=3 at word addr 2^MEM_AW-2 -> words at 1022, 1023, 0, 1; readback matches.
REQ-035 Five cmd_en while FSM blocked (write, no data) -> cmd_full after 4, err_flags[0]=1; rd_en on empty -> err_flags[2]=1.
REQ-036 Reset pulse during 32-word read burst -> all flags at reset values; after calib_done, rereading returns previously written data.
